// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer for the fetch stage.
// It picks the next fetch address from the exception, jump-register, jump,
// branch and sequential sources, and it keeps a small circular
// return-address stack that predicts the target of a return.
module pc_seq #(
    parameter int                ADDR_W    = 32,
    parameter int                STEP      = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_0080),
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [15:0]       branch_imm,
    input  logic              jump,
    input  logic [25:0]       jump_idx,
    input  logic              link,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_addr,
    input  logic              ret,
    input  logic              exc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus,
    output logic [ADDR_W-1:0] ras_top,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              addr_err
);

    localparam int               PTR_W    = $clog2(RAS_DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              addr_err_q, addr_err_d;
    logic [PTR_W-1:0]  ras_ptr_q, ras_ptr_d;
    logic [CNT_W-1:0]  ras_cnt_q, ras_cnt_d;
    logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_mem_d [RAS_DEPTH];

    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] jump_tgt;
    logic [PTR_W-1:0]  top_idx;
    logic              jr_misaligned;
    logic              do_push;
    logic              do_pop;

    // The stack pointer names the next free slot, so the newest entry sits one
    // below it; when the stack is full that free slot is also the oldest entry,
    // which is why a push on full simply overwrites it.
    assign pc_plus       = pc_q + ADDR_W'(STEP);
    assign br_off        = {{(ADDR_W-16){branch_imm[15]}}, branch_imm} << 2;
    assign br_tgt        = pc_plus + br_off;
    assign jump_tgt      = {pc_plus[ADDR_W-1:28], jump_idx, 2'b00};
    assign jr_misaligned = jr && (jr_addr[1:0] != 2'b00);
    assign top_idx       = ras_ptr_q - PTR_ONE;

    assign pc        = pc_q;
    assign addr_err  = addr_err_q;
    assign ras_empty = (ras_cnt_q == '0);
    assign ras_full  = (ras_cnt_q == CNT_FULL);
    assign ras_top   = ras_empty ? '0 : ras_mem_q[top_idx];

    // Next-PC selection; a misaligned jr traps even while stalled, and the
    // stack is touched only when a linking jump or a returning jr wins.
    always_comb begin
        pc_d       = pc_plus;
        addr_err_d = 1'b0;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        if (exc) begin
            pc_d = EXC_VEC;
        end else if (jr_misaligned) begin
            pc_d       = EXC_VEC;
            addr_err_d = 1'b1;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (jr) begin
            pc_d   = jr_addr;
            do_pop = ret;
        end else if (jump) begin
            pc_d    = jump_tgt;
            do_push = link;
        end else if (branch_taken) begin
            pc_d = br_tgt;
        end
    end

    // Return-address stack update; a pop on an empty stack leaves it alone.
    always_comb begin
        ras_mem_d = ras_mem_q;
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        if (do_push) begin
            ras_mem_d[ras_ptr_q] = pc_plus;
            ras_ptr_d            = ras_ptr_q + PTR_ONE;
            if (!ras_full) begin
                ras_cnt_d = ras_cnt_q + CNT_ONE;
            end
        end else if (do_pop && !ras_empty) begin
            ras_mem_d[top_idx] = '0;
            ras_ptr_d          = top_idx;
            ras_cnt_d          = ras_cnt_q - CNT_ONE;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_VEC;
            addr_err_q <= 1'b0;
            ras_ptr_q  <= '0;
            ras_cnt_q  <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            addr_err_q <= addr_err_d;
            ras_ptr_q  <= ras_ptr_d;
            ras_cnt_q  <= ras_cnt_d;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_q[i] <= ras_mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// Directed testbench for pc_seq with the default parameters.
module tb_pc_seq;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_idx;
    logic        link;
    logic        jr;
    logic [31:0] jr_addr;
    logic        ret;
    logic        exc;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic [31:0] ras_top;
    logic        ras_empty;
    logic        ras_full;
    logic        addr_err;

    int total;
    int bad;

    pc_seq dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_idx     (jump_idx),
        .link         (link),
        .jr           (jr),
        .jr_addr      (jr_addr),
        .ret          (ret),
        .exc          (exc),
        .pc           (pc),
        .pc_plus      (pc_plus),
        .ras_top      (ras_top),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full),
        .addr_err     (addr_err)
    );

    // 10 ns free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge and settle 1 ns past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall        = 1'b0;
        branch_taken = 1'b0;
        branch_imm   = 16'h0000;
        jump         = 1'b0;
        jump_idx     = 26'h0;
        link         = 1'b0;
        jr           = 1'b0;
        jr_addr      = 32'h0;
        ret          = 1'b0;
        exc          = 1'b0;
    endtask

    // plain aligned jr (no ret) to place the PC somewhere
    task automatic goto_pc(input logic [31:0] addr);
        jr      = 1'b1;
        jr_addr = addr;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'd4;
        exp_seq[1] = 32'd8;
        exp_seq[2] = 32'd12;
        tick();
        total++;
        if (pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        total++;
        if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_ras_flags got=%b%b exp=10", ras_empty, ras_full); end
        total++;
        if (addr_err !== 1'b0 || ras_top !== 32'h0) begin bad++; $display("[TB] FAIL reset_misc addr_err=%b ras_top=%h exp=0/0", addr_err, ras_top); end
        tick();
        total++;
        if (pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_hold got=%h exp=%h", pc, 32'h0); end
        rst = 1'b1;
        #1;
        total++;
        if (pc !== 32'h0 || pc_plus !== 32'h4) begin bad++; $display("[TB] FAIL release_first pc=%h pc_plus=%h exp=0/4", pc, pc_plus); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (pc !== exp_seq[i]) begin bad++; $display("[TB] FAIL seq_%0d got=%h exp=%h", i, pc, exp_seq[i]); end
        end
        total++;
        if (ras_empty !== 1'b1 || addr_err !== 1'b0) begin bad++; $display("[TB] FAIL seq_flags empty=%b addr_err=%b exp=1/0", ras_empty, addr_err); end
    endtask

    task automatic test_stall_branch();
        goto_pc(32'h100);
        total++;
        if (pc !== 32'h100) begin bad++; $display("[TB] FAIL goto_100 got=%h exp=%h", pc, 32'h100); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (pc !== 32'h100) begin bad++; $display("[TB] FAIL stall_hold_%0d got=%h exp=%h", i, pc, 32'h100); end
        end
        stall        = 1'b0;
        branch_taken = 1'b1;
        branch_imm   = 16'hFFFE;
        tick();
        clear_inputs();
        total++;
        if (pc !== 32'hFC) begin bad++; $display("[TB] FAIL branch_back got=%h exp=%h", pc, 32'hFC); end
        // branch requested during stall is dropped
        stall        = 1'b1;
        branch_taken = 1'b1;
        branch_imm   = 16'h0010;
        tick();
        clear_inputs();
        total++;
        if (pc !== 32'hFC) begin bad++; $display("[TB] FAIL branch_stalled got=%h exp=%h", pc, 32'hFC); end
    endtask

    task automatic test_jal_ret();
        goto_pc(32'h1000_0040);
        jump     = 1'b1;
        link     = 1'b1;
        jump_idx = 26'h0000_200;
        tick();
        clear_inputs();
        total++;
        if (pc !== 32'h1000_0800) begin bad++; $display("[TB] FAIL jal_pc got=%h exp=%h", pc, 32'h1000_0800); end
        total++;
        if (ras_top !== 32'h1000_0044 || ras_empty !== 1'b0) begin bad++; $display("[TB] FAIL jal_push top=%h empty=%b exp=10000044/0", ras_top, ras_empty); end
        // link and ret without jump/jr leave the stack alone
        link = 1'b1;
        ret  = 1'b1;
        tick();
        clear_inputs();
        total++;
        if (pc !== 32'h1000_0804 || ras_top !== 32'h1000_0044) begin bad++; $display("[TB] FAIL stray_link_ret pc=%h top=%h exp=10000804/10000044", pc, ras_top); end
        jr      = 1'b1;
        ret     = 1'b1;
        jr_addr = 32'h1000_0044;
        tick();
        clear_inputs();
        total++;
        if (pc !== 32'h1000_0044) begin bad++; $display("[TB] FAIL ret_pc got=%h exp=%h", pc, 32'h1000_0044); end
        total++;
        if (ras_empty !== 1'b1 || ras_top !== 32'h0) begin bad++; $display("[TB] FAIL ret_pop empty=%b top=%h exp=1/0", ras_empty, ras_top); end
    endtask

    task automatic test_ras_overflow();
        logic [25:0] idx   [5];
        logic [31:0] tgt   [5];
        logic [31:0] pushv [5];
        idx[0] = 26'h1000; tgt[0] = 32'h0000_4000; pushv[0] = 32'h0000_2004;
        idx[1] = 26'h2000; tgt[1] = 32'h0000_8000; pushv[1] = 32'h0000_4004;
        idx[2] = 26'h3000; tgt[2] = 32'h0000_C000; pushv[2] = 32'h0000_8004;
        idx[3] = 26'h4000; tgt[3] = 32'h0001_0000; pushv[3] = 32'h0000_C004;
        idx[4] = 26'h5000; tgt[4] = 32'h0001_4000; pushv[4] = 32'h0001_0004;
        goto_pc(32'h2000);
        for (int i = 0; i < 5; i++) begin
            jump     = 1'b1;
            link     = 1'b1;
            jump_idx = idx[i];
            tick();
            clear_inputs();
            total++;
            if (pc !== tgt[i] || ras_top !== pushv[i]) begin bad++; $display("[TB] FAIL push_%0d pc=%h top=%h exp=%h/%h", i, pc, ras_top, tgt[i], pushv[i]); end
        end
        total++;
        if (ras_full !== 1'b1) begin bad++; $display("[TB] FAIL ras_full got=%b exp=1", ras_full); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ras_top !== pushv[4-i]) begin bad++; $display("[TB] FAIL pop_order_%0d got=%h exp=%h", i, ras_top, pushv[4-i]); end
            jr      = 1'b1;
            ret     = 1'b1;
            jr_addr = 32'h300 + 32'(4 * i);
            tick();
            clear_inputs();
        end
        total++;
        if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin bad++; $display("[TB] FAIL drained empty=%b full=%b exp=1/0", ras_empty, ras_full); end
        jr      = 1'b1;
        ret     = 1'b1;
        jr_addr = 32'h400;
        tick();
        clear_inputs();
        total++;
        if (pc !== 32'h400 || ras_empty !== 1'b1 || ras_top !== 32'h0) begin bad++; $display("[TB] FAIL pop_empty pc=%h empty=%b top=%h exp=400/1/0", pc, ras_empty, ras_top); end
    endtask

    task automatic test_back_to_back();
        // one push, then jump+link and jr+ret together: jr wins, pop only
        jump     = 1'b1;
        link     = 1'b1;
        jump_idx = 26'h0800;
        tick();
        clear_inputs();
        total++;
        if (pc !== 32'h2000 || ras_top !== 32'h404) begin bad++; $display("[TB] FAIL b2b_push pc=%h top=%h exp=2000/404", pc, ras_top); end
        jump     = 1'b1;
        link     = 1'b1;
        jump_idx = 26'h0800;
        jr       = 1'b1;
        ret      = 1'b1;
        jr_addr  = 32'h500;
        tick();
        clear_inputs();
        total++;
        if (pc !== 32'h500 || ras_empty !== 1'b1) begin bad++; $display("[TB] FAIL b2b_pop_only pc=%h empty=%b exp=500/1", pc, ras_empty); end
    endtask

    task automatic test_misaligned();
        goto_pc(32'h3000);
        jump     = 1'b1;
        link     = 1'b1;
        jump_idx = 26'h1000;
        tick();
        clear_inputs();
        stall   = 1'b1;
        jr      = 1'b1;
        ret     = 1'b1;
        jr_addr = 32'h202;
        tick();
        clear_inputs();
        total++;
        if (pc !== 32'h80 || addr_err !== 1'b1) begin bad++; $display("[TB] FAIL misaligned pc=%h addr_err=%b exp=80/1", pc, addr_err); end
        total++;
        if (ras_top !== 32'h3004 || ras_empty !== 1'b0) begin bad++; $display("[TB] FAIL misaligned_ras top=%h empty=%b exp=3004/0", ras_top, ras_empty); end
        tick();
        total++;
        if (pc !== 32'h84 || addr_err !== 1'b0) begin bad++; $display("[TB] FAIL addr_err_pulse pc=%h addr_err=%b exp=84/0", pc, addr_err); end
        stall = 1'b1;
        exc   = 1'b1;
        tick();
        clear_inputs();
        total++;
        if (pc !== 32'h80 || ras_top !== 32'h3004) begin bad++; $display("[TB] FAIL exc_stall pc=%h top=%h exp=80/3004", pc, ras_top); end
    endtask

    task automatic test_wrap_reset();
        goto_pc(32'hFFFF_FFFC);
        total++;
        if (pc_plus !== 32'h0) begin bad++; $display("[TB] FAIL wrap_pc_plus got=%h exp=0", pc_plus); end
        tick();
        total++;
        if (pc !== 32'h0) begin bad++; $display("[TB] FAIL wrap got=%h exp=0", pc); end
        tick();
        total++;
        if (pc !== 32'h4 || ras_empty !== 1'b0) begin bad++; $display("[TB] FAIL pre_reset pc=%h empty=%b exp=4/0", pc, ras_empty); end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (pc !== 32'h0 || ras_empty !== 1'b1 || ras_top !== 32'h0 || ras_full !== 1'b0) begin bad++; $display("[TB] FAIL async_reset pc=%h empty=%b top=%h full=%b exp=0/1/0/0", pc, ras_empty, ras_top, ras_full); end
        tick();
        total++;
        if (pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_held got=%h exp=0", pc); end
        rst = 1'b1;
        tick();
        total++;
        if (pc !== 32'h4) begin bad++; $display("[TB] FAIL post_reset got=%h exp=4", pc); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        clear_inputs();
        test_reset();
        test_stall_branch();
        test_jal_ret();
        test_ras_overflow();
        test_back_to_back();
        test_misaligned();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
